// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//   Turns the PS/2 Set-2 scan-code byte stream into ASCII characters and
//   queues them in a small show-ahead FIFO for a memory-mapped CPU port.
//   The E0 (extended) and F0 (break) prefixes are parsed, and the Shift and
//   Caps Lock state is tracked to pick the letter case.
//
// Ports
//   inclock            system clock, rising edge
//   reset              synchronous, active-high reset
//   ps2_key_data       scan-code byte, valid while ps2_received_data is high
//   ps2_received_data  one-cycle byte strobe
//   rd_en              pop request from the CPU port
//   key_ascii          FIFO head character, 8'h00 when empty
//   key_valid          FIFO not empty
//   key_count          number of queued characters, 0..DEPTH
//   overflow           sticky, a character was dropped because the FIFO was full
//   shift_held         left or right Shift currently down
//   caps_lock          Caps Lock toggle state
module ps2_key_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              inclock,
  input  logic              reset,
  input  logic [7:0]        ps2_key_data,
  input  logic              ps2_received_data,
  input  logic              rd_en,
  output logic [7:0]        key_ascii,
  output logic              key_valid,
  output logic [ADDR_W:0]   key_count,
  output logic              overflow,
  output logic              shift_held,
  output logic              caps_lock
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t              state;
  logic                lshift;
  logic                rshift;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;

  logic                push_req;
  logic [7:0]          push_char;
  logic                push_ok;
  logic                pop;

  // Make code to ASCII; letters come back uppercase when upper is set.
  // Every code not in the table (including prefixes and status bytes such
  // as E1, AA, FA, EE, FE) maps to 0, which means "nothing to push".
  function automatic logic [7:0] xlate(input logic [7:0] b, input logic upper);
    logic [7:0] c;
    c = 8'h00;
    case (b)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
      8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
      8'h3E: c = "8";  8'h46: c = "9";
      8'h29: c = 8'h20;
      8'h5A: c = 8'h0D;
      8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (upper && (c >= 8'h61) && (c <= 8'h7A)) c = c - 8'h20;
    return c;
  endfunction

  assign shift_held = lshift | rshift;
  assign key_valid  = (count != '0);
  assign key_count  = count;
  assign key_ascii  = key_valid ? mem[rd_ptr] : 8'h00;

  // Character to push this cycle. Case uses the Shift/Caps state held
  // before the current byte, since the flags update on the same edge.
  always_comb begin
    push_req  = 1'b0;
    push_char = 8'h00;
    if (ps2_received_data) begin
      if (state == IDLE) begin
        push_char = xlate(ps2_key_data, shift_held ^ caps_lock);
        push_req  = (push_char != 8'h00);
      end else if ((state == EXT) && (ps2_key_data == 8'h5A)) begin
        push_char = 8'h0D;
        push_req  = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when a pop frees the head slot.
  assign pop     = rd_en & key_valid;
  assign push_ok = push_req & ((count != CNT_FULL) | pop);

  // Parser stage: FSM and modifier flags, stepping only on byte strobes.
  always_ff @(posedge inclock) begin
    if (reset) begin
      state     <= IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
    end else if (ps2_received_data) begin
      case (state)
        IDLE: begin
          case (ps2_key_data)
            8'hE0: state <= EXT;
            8'hF0: state <= BRK;
            8'h12: lshift <= 1'b1;
            8'h59: rshift <= 1'b1;
            8'h58: caps_lock <= ~caps_lock;
            default: state <= IDLE;
          endcase
        end
        EXT: begin
          state <= (ps2_key_data == 8'hF0) ? EXT_BRK : IDLE;
        end
        BRK: begin
          if (ps2_key_data == 8'h12) lshift <= 1'b0;
          if (ps2_key_data == 8'h59) rshift <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO stage: pointers, occupancy and sticky overflow.
  always_ff @(posedge inclock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; key_valid gates stale contents.
  always_ff @(posedge inclock) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

  logic       inclock = 1'b0;
  logic       reset;
  logic [7:0] ps2_key_data;
  logic       ps2_received_data;
  logic       rd_en;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic [3:0] key_count;
  logic       overflow;
  logic       shift_held;
  logic       caps_lock;

  int checks = 0;
  int errors = 0;

  ps2_key_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .inclock           (inclock),
    .reset             (reset),
    .ps2_key_data      (ps2_key_data),
    .ps2_received_data (ps2_received_data),
    .rd_en             (rd_en),
    .key_ascii         (key_ascii),
    .key_valid         (key_valid),
    .key_count         (key_count),
    .overflow          (overflow),
    .shift_held        (shift_held),
    .caps_lock         (caps_lock)
  );

  always #5 inclock = ~inclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe, optionally with rd_en in the same cycle; returns at the
  // following falling edge where the result is already visible.
  task automatic send(input logic [7:0] b, input logic rd);
    @(negedge inclock);
    ps2_key_data      = b;
    ps2_received_data = 1'b1;
    rd_en             = rd;
    @(negedge inclock);
    ps2_received_data = 1'b0;
    rd_en             = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge inclock);
    rd_en = 1'b1;
    @(negedge inclock);
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_count"}, key_count, 0);
    check({tag, "_ascii"}, key_ascii, 0);
    check({tag, "_ovf"},   overflow, 0);
    check({tag, "_shift"}, shift_held, 0);
    check({tag, "_caps"},  caps_lock, 0);
  endtask

  initial begin
    logic [7:0] drain [8];
    logic [7:0] fill  [9];

    reset = 1'b1; ps2_key_data = 8'h00; ps2_received_data = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge inclock);
    @(negedge inclock);
    reset = 1'b0;
    check_reset_state("rst");

    // Single make code, then pop
    send(8'h1C, 1'b0);
    check("a_valid", key_valid, 1);
    check("a_ascii", key_ascii, 8'h61);
    check("a_count", key_count, 1);
    pop_one();
    check("a_pop_valid", key_valid, 0);
    check("a_pop_ascii", key_ascii, 0);

    // Empty pop is ignored, no underflow
    pop_one();
    check("empty_pop_count", key_count, 0);

    // Shift make/break around letters
    send(8'h12, 1'b0);
    check("sh_held", shift_held, 1);
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    check("sh_brk_nopush", key_count, 1);
    send(8'hF0, 1'b0);
    send(8'h12, 1'b0);
    check("sh_released", shift_held, 0);
    send(8'h1C, 1'b0);
    check("sh_count", key_count, 2);
    check("sh_head_A", key_ascii, 8'h41);
    pop_one();
    check("sh_head_a", key_ascii, 8'h61);
    pop_one();
    check("sh_empty", key_valid, 0);

    // Caps Lock with Shift cancels back to lowercase
    send(8'h58, 1'b0);
    check("caps_on", caps_lock, 1);
    send(8'hF0, 1'b0);
    send(8'h58, 1'b0);
    check("caps_brk_keeps", caps_lock, 1);
    send(8'h59, 1'b0);
    check("rshift_held", shift_held, 1);
    send(8'h32, 1'b0);
    check("caps_sh_b", key_ascii, 8'h62);
    check("caps_sh_count", key_count, 1);
    send(8'h58, 1'b0);
    check("caps_off", caps_lock, 0);
    send(8'hF0, 1'b0);
    send(8'h59, 1'b0);
    check("rshift_rel", shift_held, 0);
    pop_one();

    // Extended sequences and ignored status bytes
    send(8'hE0, 1'b0); send(8'h5A, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h5A, 1'b0);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hF0, 1'b0); send(8'h45, 1'b0);
    send(8'hFA, 1'b0); send(8'hAA, 1'b0);
    check("ext_count", key_count, 1);
    check("ext_enter", key_ascii, 8'h0D);
    send(8'h16, 1'b0);
    check("ext_idle_count", key_count, 2);
    pop_one();
    check("ext_digit1", key_ascii, 8'h31);
    pop_one();
    check("ext_empty", key_valid, 0);

    // Push and pop together while empty: push wins
    send(8'h29, 1'b1);
    check("pp_empty_count", key_count, 1);
    check("pp_empty_space", key_ascii, 8'h20);
    pop_one();

    // Overflow: 9 pushes into 8 entries
    fill = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    for (int i = 0; i < 9; i++) send(fill[i], 1'b0);
    check("full_count", key_count, 8);
    check("full_ovf", overflow, 1);
    check("full_head", key_ascii, 8'h61);

    // Full with push+pop: count stays full, new char goes in after wrap
    send(8'h42, 1'b1);
    check("fpp_count", key_count, 8);
    check("fpp_ovf", overflow, 1);
    drain = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6B};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), key_ascii, drain[i]);
      pop_one();
    end
    check("drain_empty", key_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-sequence with dirty state, coinciding with the final byte
    send(8'h58, 1'b0);
    send(8'h12, 1'b0);
    send(8'h1C, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    @(negedge inclock);
    reset = 1'b1; ps2_key_data = 8'h5A; ps2_received_data = 1'b1;
    @(negedge inclock);
    reset = 1'b0; ps2_received_data = 1'b0;
    check_reset_state("rst2");
    send(8'h1C, 1'b0);
    check("post_rst_a", key_ascii, 8'h61);
    check("post_rst_count", key_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Consumes the byte stream from the PS/2 interface (`ps2_key_data` qualified by the one-cycle `ps2_received_data` strobe). It parses Set-2 scan-code framing (E0 extended prefix, F0 break prefix) and tracks Shift and Caps Lock state. Printable make codes are translated to ASCII and queued in a small show-ahead FIFO. The processor's memory-mapped keyboard port pops that FIFO one character per read.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, 3: log2(`DEPTH`).

Ports (clock and reset first):
- `inclock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key_data`  in  8  scan-code byte; valid only while the strobe is high.
- `ps2_received_data`  in  1  one-cycle byte strobe from the PS/2 interface.
- `rd_en`  in  1  pop request from the CPU port.
- `key_ascii`  out  8  FIFO head character; 8'h00 when empty.
- `key_valid`  out  1  FIFO not empty.
- `key_count`  out  ADDR_W+1  number of queued characters, 0..DEPTH.
- `overflow`  out  1  sticky; set when a character is dropped because the FIFO is full.
- `shift_held`  out  1  left or right Shift currently down.
- `caps_lock`  out  1  Caps Lock toggle state.

## Operation
Reset clears the FIFO (pointers and count to 0), clears `overflow`, `shift_held` and `caps_lock`, and puts the parser in IDLE. Reset takes priority over every other input in the same cycle, including a byte mid-sequence.

Parser FSM steps only on cycles where `ps2_received_data`=1; otherwise it holds. Let b = `ps2_key_data`.
- IDLE:
  - b=E0 → EXT.
  - b=F0 → BRK.
  - b=12 or 59 → set the corresponding Shift flag; stay in IDLE.
  - b=58 → toggle `caps_lock`; stay in IDLE.
  - Otherwise, if the translation of b is non-zero, push it; stay in IDLE.
- EXT:
  - b=F0 → EXT_BRK.
  - b=5A (keypad Enter) → push 8'h0D, go to IDLE.
  - Any other byte → IDLE with no push.
- BRK: b=12 or 59 → clear that Shift flag. Any byte returns to IDLE with no push.
- EXT_BRK: any byte → IDLE with no push.
- Bytes E1, AA, FA, EE and FE in IDLE translate to 0 and are ignored.
- `shift_held` = left Shift flag OR right Shift flag.

Translation (make code → ASCII; every unlisted code → 0):
- Letters, lowercase base: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
- A letter is output in uppercase (subtract 8'h20) when `shift_held` XOR `caps_lock`.
- Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'. Shift does not affect digits.
- 29 → 8'h20 (space), 5A → 8'h0D (Enter), 66 → 8'h08 (Backspace).
- Shift state used for the case decision is the value held before the current byte.

FIFO:
- Write pointer, read pointer and count; pointers wrap modulo `DEPTH`.
- Pop occurs when `rd_en` & `key_valid`. `rd_en` while empty is ignored.
- Push when not full is accepted.
- Push while full with a simultaneous pop: both happen, and count stays at `DEPTH`.
- Push while full with no pop: the character is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop in the same cycle while count is 0: the push is accepted, and the pop is ignored because `key_valid`=0.
- `key_ascii` is combinational from the head entry (show-ahead), gated to 0 when empty.

## Timing
- A strobe sampled at edge N makes its push visible after edge N: `key_valid`, `key_count` and `key_ascii` update the next cycle. Latency is 1 cycle.
- A pop at edge N makes the next head visible after edge N.
- `caps_lock`, `shift_held` and the FSM state update at the strobe edge.
- Back-to-back strobes on consecutive cycles must be handled.
- No combinational path from `ps2_key_data` or `ps2_received_data` to any output.

## Test plan
- Reset with inputs idle, then strobe 1C → after 1 cycle `key_valid`=1, `key_ascii`=8'h61, `key_count`=1. `rd_en` for 1 cycle → `key_valid`=0, `key_ascii`=0.
- Sequence 12, 1C, F0 1C, F0 12, 1C → FIFO holds 'A','a'. `shift_held` reads 1 after byte 12 and 0 after F0 12; no push occurs for any break code.
- Sequence 58, F0 58, 12, 32 → `caps_lock`=1 and Shift is held, so the output is 'b' (8'h62). Then 58 again → `caps_lock`=0.
- Sequence E0 5A, E0 F0 5A, E0 75, F0 45 → exactly one entry, 8'h0D. FSM back in IDLE, proven by a following 16 pushing '1'.
- Push 9 characters with `DEPTH`=8 and no reads → count=8 and `overflow`=1; the 9th character is dropped, and the FIFO drains the first 8 in order. Full FIFO with push and pop on the same edge → count stays 8 and order is preserved across the pointer wrap.
- Assert `reset` after E0 F0, before the final byte → all outputs return to reset values. The next byte 1C pushes 'a'.
